// File: rtl/multi_edge_pkg.sv
// Shared types for the multi-channel edge detector: FSM state encodings,
// per-channel mode codes and a popcount helper for the event counter.
package multi_edge_pkg;

    typedef enum logic {
        MEALY_LOW  = 1'b0,
        MEALY_HIGH = 1'b1
    } mealy_st_t;

    typedef enum logic [1:0] {
        MOORE_LOW  = 2'd0,
        MOORE_RISE = 2'd1,
        MOORE_HIGH = 2'd2,
        MOORE_FALL = 2'd3
    } moore_st_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/multi_edge_detector_edge_chan.sv
// One detector channel: optional debounce, Mealy and Moore edge FSMs, sticky flag.
// Debounce is compiled in only when MULTI_EDGE_DEBOUNCE_EN is defined.
module edge_chan
    import multi_edge_pkg::*;
`ifdef MULTI_EDGE_DEBOUNCE_EN
#(
    parameter int DEB_LEN = 3
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       mealy_tick,
    output logic       moore_tick,
    output logic       evt_flag
);

    logic      lvl_f;
    logic      rise_en;
    logic      fall_en;
    mealy_st_t mealy_st, mealy_nxt;
    moore_st_t moore_st, moore_nxt;
    logic      moore_tick_nxt;

    assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

`ifdef MULTI_EDGE_DEBOUNCE_EN
    logic       lvl_r;
    logic [3:0] deb_cnt;

    // Counter only advances while the raw level disagrees; any agreement restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_r   <= 1'b0;
            deb_cnt <= '0;
        end else if (level != lvl_r) begin
            if (deb_cnt == 4'(DEB_LEN - 1)) begin
                lvl_r   <= level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 4'd1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign lvl_f = lvl_r;
`else
    assign lvl_f = level;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mealy_st   <= MEALY_LOW;
            moore_st   <= MOORE_LOW;
            moore_tick <= 1'b0;
        end else begin
            mealy_st   <= mealy_nxt;
            moore_st   <= moore_nxt;
            moore_tick <= moore_tick_nxt;
        end
    end

    // States always follow lvl_f; mode only gates the ticks.
    always_comb begin
        mealy_nxt  = mealy_st;
        mealy_tick = 1'b0;
        case (mealy_st)
            MEALY_LOW:  if (lvl_f)  begin mealy_nxt = MEALY_HIGH; mealy_tick = rise_en; end
            MEALY_HIGH: if (!lvl_f) begin mealy_nxt = MEALY_LOW;  mealy_tick = fall_en; end
        endcase
        // The combinational path would otherwise see a high level through reset.
        if (!rst) mealy_tick = 1'b0;
    end

    always_comb begin
        moore_nxt = moore_st;
        case (moore_st)
            MOORE_LOW:  moore_nxt = lvl_f ? MOORE_RISE : MOORE_LOW;
            MOORE_RISE: moore_nxt = lvl_f ? MOORE_HIGH : MOORE_FALL;
            MOORE_HIGH: moore_nxt = lvl_f ? MOORE_HIGH : MOORE_FALL;
            MOORE_FALL: moore_nxt = lvl_f ? MOORE_RISE : MOORE_LOW;
        endcase
        moore_tick_nxt = ((moore_nxt == MOORE_RISE) && rise_en) ||
                         ((moore_nxt == MOORE_FALL) && fall_en);
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            evt_flag <= 1'b0;
        else if (mealy_tick) evt_flag <= 1'b1;
        else if (clr)        evt_flag <= 1'b0;
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent edge-detector channels plus a shared saturating event counter.
// Optional per-channel debounce enabled by defining MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detector
    import multi_edge_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int DEB_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    input  logic              cnt_clr,
    output logic [N_CH-1:0]   mealy_tick,
    output logic [N_CH-1:0]   moore_tick,
    output logic [N_CH-1:0]   evt_flag,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int         SUM_W   = CNT_W + 6;
    localparam [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (N_CH < 1 || N_CH > 32 || DEB_LEN < 1 || DEB_LEN > 15) begin : g_param_err
        $error("multi_edge_detector: N_CH or DEB_LEN out of range");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_chan
`ifdef MULTI_EDGE_DEBOUNCE_EN
            #(.DEB_LEN(DEB_LEN))
`endif
        u_chan (
            .clk        (clk),
            .rst        (rst),
            .level      (level[i]),
            .mode       (mode[2*i+1:2*i]),
            .clr        (clr[i]),
            .mealy_tick (mealy_tick[i]),
            .moore_tick (moore_tick[i]),
            .evt_flag   (evt_flag[i])
        );
    end

    logic [31:0]      tick_ext;
    logic [SUM_W-1:0] sum;

    assign tick_ext = 32'(mealy_tick);
    assign sum      = SUM_W'(evt_cnt) + SUM_W'(popcount(tick_ext));

    // Clear discards same-cycle ticks; otherwise saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       evt_cnt <= '0;
        else if (cnt_clr)               evt_cnt <= '0;
        else if (sum > SUM_W'(CNT_MAX)) evt_cnt <= CNT_MAX;
        else                            evt_cnt <= sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default DUT plus a CNT_W=3 copy for saturation.
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] level = '0, clr = '0;
    logic [7:0] mode = '0;
    logic       cnt_clr = 1'b0;
    logic [3:0] mealy_tick, moore_tick, evt_flag;
    logic [7:0] evt_cnt;

    logic [3:0] level1 = '0, clr1 = '0;
    logic [7:0] mode1 = 8'hFF;
    logic       cnt_clr1 = 1'b0;
    logic [3:0] mealy_tick1, moore_tick1, evt_flag1;
    logic [2:0] evt_cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(.N_CH(4), .CNT_W(8), .DEB_LEN(3)) u0 (
        .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .mealy_tick(mealy_tick), .moore_tick(moore_tick), .evt_flag(evt_flag), .evt_cnt(evt_cnt)
    );

    multi_edge_detector #(.N_CH(4), .CNT_W(3), .DEB_LEN(3)) u1 (
        .clk(clk), .rst(rst), .level(level1), .mode(mode1), .clr(clr1), .cnt_clr(cnt_clr1),
        .mealy_tick(mealy_tick1), .moore_tick(moore_tick1), .evt_flag(evt_flag1), .evt_cnt(evt_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) nxt();
        smp();
        chk("rst_mealy", 32'(mealy_tick), 0);
        chk("rst_moore", 32'(moore_tick), 0);
        chk("rst_flag", 32'(evt_flag), 0);
        chk("rst_cnt", 32'(evt_cnt), 0);
        chk("rst_cnt_u1", 32'(evt_cnt1), 0);
        nxt(); rst = 1'b1; mode = 8'h01; smp();

`ifdef MULTI_EDGE_DEBOUNCE_EN
        // 2-cycle glitch must be swallowed
        nxt(); level = 4'b0001; smp(); chk("deb_g1", 32'(mealy_tick), 0);
        nxt(); smp();                  chk("deb_g2", 32'(mealy_tick), 0);
        nxt(); level = 4'b0000; smp(); chk("deb_g3", 32'(mealy_tick), 0);
        nxt(); smp();                  chk("deb_g4", 32'(mealy_tick), 0);
        // 3 stable cycles then one rise tick
        nxt(); level = 4'b0001; smp(); chk("deb_s1", 32'(mealy_tick), 0);
        nxt(); smp();                  chk("deb_s2", 32'(mealy_tick), 0);
        nxt(); smp();                  chk("deb_s3", 32'(mealy_tick), 0);
        nxt(); smp();                  chk("deb_rise_mealy", 32'(mealy_tick), 32'h1);
        chk("deb_rise_moore0", 32'(moore_tick), 0);
        nxt(); smp();
        chk("deb_after_mealy", 32'(mealy_tick), 0);
        chk("deb_rise_moore", 32'(moore_tick), 32'h1);
        chk("deb_cnt", 32'(evt_cnt), 1);
`else
        // ch0 rising edge, rise-only mode
        nxt(); level = 4'b0001; smp();
        chk("t1_mealy", 32'(mealy_tick), 32'h1);
        chk("t1_moore_early", 32'(moore_tick), 0);
        chk("t1_cnt_early", 32'(evt_cnt), 0);
        nxt(); smp();
        chk("t1_mealy_end", 32'(mealy_tick), 0);
        chk("t1_moore", 32'(moore_tick), 32'h1);
        chk("t1_cnt", 32'(evt_cnt), 1);
        chk("t1_flag", 32'(evt_flag), 32'h1);
        nxt(); smp();
        chk("t1_moore_end", 32'(moore_tick), 0);
        nxt(); level = 4'b0000; smp();
        chk("t1_fall_gated", 32'(mealy_tick), 0);
        nxt(); smp();
        chk("t1_fall_moore_gated", 32'(moore_tick), 0);
        chk("t1_cnt_hold", 32'(evt_cnt), 1);

        // ch1 one-cycle pulse, both edges
        nxt(); mode = 8'h0D; cnt_clr = 1'b1; smp();
        nxt(); cnt_clr = 1'b0; level = 4'b0010; smp();
        chk("t2_rise_mealy", 32'(mealy_tick), 32'h2);
        chk("t2_rise_moore0", 32'(moore_tick), 0);
        chk("t2_cnt0", 32'(evt_cnt), 0);
        nxt(); level = 4'b0000; smp();
        chk("t2_fall_mealy", 32'(mealy_tick), 32'h2);
        chk("t2_rise_moore", 32'(moore_tick), 32'h2);
        chk("t2_cnt1", 32'(evt_cnt), 1);
        nxt(); smp();
        chk("t2_mealy_end", 32'(mealy_tick), 0);
        chk("t2_fall_moore", 32'(moore_tick), 32'h2);
        chk("t2_cnt2", 32'(evt_cnt), 2);
        chk("t2_flag", 32'(evt_flag), 32'h3);
        nxt(); smp();
        chk("t2_moore_end", 32'(moore_tick), 0);
        chk("t2_flag_hold", 32'(evt_flag), 32'h3);
        nxt(); clr = 4'b0010; smp();
        chk("t2_flag_clr_cycle", 32'(evt_flag), 32'h3);
        nxt(); clr = 4'b0000; smp();
        chk("t2_flag_cleared", 32'(evt_flag), 32'h1);

        // all channels rise together
        nxt(); mode = 8'h55; level = 4'hF; smp();
        chk("t3_mealy", 32'(mealy_tick), 32'hF);
        chk("t3_cnt_pre", 32'(evt_cnt), 2);
        nxt(); smp();
        chk("t3_moore", 32'(moore_tick), 32'hF);
        chk("t3_cnt", 32'(evt_cnt), 6);
        nxt(); level = 4'h0; smp();
        chk("t3_fall_gated", 32'(mealy_tick), 0);
        nxt(); clr = 4'hF; smp();
        nxt(); clr = 4'h0; smp();
        chk("t3_flags_clr", 32'(evt_flag), 0);

        // set beats clear; cnt_clr beats ticks
        nxt(); level = 4'b0100; clr = 4'b0100; smp();
        chk("t4_mealy2", 32'(mealy_tick), 32'h4);
        nxt(); clr = 4'b0000; smp();
        chk("t4_set_wins", 32'(evt_flag), 32'h4);
        chk("t4_cnt", 32'(evt_cnt), 7);
        nxt(); level = 4'b1100; cnt_clr = 1'b1; smp();
        chk("t4_mealy3", 32'(mealy_tick), 32'h8);
        nxt(); cnt_clr = 1'b0; smp();
        chk("t4_cnt_clr_wins", 32'(evt_cnt), 0);
        chk("t4_flags", 32'(evt_flag), 32'hC);

        // CNT_W=3 saturation with 9 edges
        nxt(); level1 = 4'hF; smp();
        chk("t5_mealy", 32'(mealy_tick1), 32'hF);
        nxt(); level1 = 4'h0; smp();
        chk("t5_cnt4", 32'(evt_cnt1), 4);
        nxt(); level1 = 4'h1; smp();
        chk("t5_cnt_sat", 32'(evt_cnt1), 7);
        nxt(); smp();
        chk("t5_cnt_sat2", 32'(evt_cnt1), 7);
        nxt(); smp();
        chk("t5_cnt_sat3", 32'(evt_cnt1), 7);

        // reset while ch2/ch3 high
        nxt(); rst = 1'b0; smp();
        chk("t6_rst_mealy", 32'(mealy_tick), 0);
        chk("t6_rst_moore", 32'(moore_tick), 0);
        chk("t6_rst_flag", 32'(evt_flag), 0);
        nxt(); smp();
        chk("t6_rst_mealy2", 32'(mealy_tick), 0);
        chk("t6_rst_cnt", 32'(evt_cnt), 0);
        nxt(); rst = 1'b1; smp();
        chk("t6_rel_mealy", 32'(mealy_tick), 32'hC);
        chk("t6_rel_moore0", 32'(moore_tick), 0);
        nxt(); smp();
        chk("t6_rel_mealy_end", 32'(mealy_tick), 0);
        chk("t6_rel_moore", 32'(moore_tick), 32'hC);
        chk("t6_rel_cnt", 32'(evt_cnt), 2);
        nxt(); smp();
        chk("t6_moore_end", 32'(moore_tick), 0);
        chk("t6_cnt_hold", 32'(evt_cnt), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
